xbtn_ctrl: RTL and testbench

XBTN_CTRL -- requirements
Module: xbtn_ctrl

---
 rtl/xbtn_pkg.sv | 29 ++
 rtl/xbtn_if.sv | 11 +
 rtl/xbtn_debounce.sv | 44 ++++
 rtl/xbtn_ctrl.sv | 126 ++++++++++++
 tb/tb_xbtn_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbtn_pkg.sv
// Shared register-map constants and helpers for the push-button controller.
package xbtn_pkg;

  typedef enum logic [1:0] {
    RegLevel = 2'd0,
    RegPend  = 2'd1,
    RegEvq   = 2'd2,
    RegCtrl  = 2'd3
  } reg_addr_e;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlFlushBit = 1;
  localparam int unsigned CtrlDropBit  = 8;
  localparam int unsigned EvqValidBit  = 31;

  function automatic logic [7:0] lowest_index(logic [7:0] vec);
    logic [7:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(logic [7:0] vec);
    return (vec & (vec - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/xbtn_if.sv
// Register bus between the address decoder (master) and the button controller (slave).
interface xbtn_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output sel, output we, output addr, output data_in, input data_out);
  modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/xbtn_debounce.sv
// One button: 2-flop synchronizer, tick-driven debounce counter and stable level.
module xbtn_debounce #(
  parameter int unsigned DEB_CNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  logic       sync1_q, sync2_q, stable_q;
  logic [7:0] cnt_q;
  logic       accept;

  // Level is accepted on the tick that completes DEB_CNT consecutive differing ticks.
  assign accept = tick && (sync2_q != stable_q) && (cnt_q == 8'(DEB_CNT - 1));
  assign stable = stable_q;
  assign press  = accept && sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      if (tick) begin
        if (sync2_q == stable_q) begin
          cnt_q <= 8'd0;
        end else if (accept) begin
          cnt_q    <= 8'd0;
          stable_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/xbtn_ctrl.sv
// Push-button controller: shared debounce prescaler, pending bits, event FIFO and CTRL register.
module xbtn_ctrl
  import xbtn_pkg::*;
#(
  parameter int unsigned NBTN      = 4,
  parameter int unsigned DEB_DIV   = 50000,
  parameter int unsigned DEB_CNT   = 10,
  parameter int unsigned EVQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  xbtn_if.slave           bus,
  input  logic [NBTN-1:0] btn_raw,
  output logic            irq
);

  localparam int unsigned DivW = $clog2(DEB_DIV);
  localparam int unsigned AW   = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(EVQ_DEPTH + 1);

  logic [DivW-1:0] div_q;
  logic            tick;
  logic [NBTN-1:0] level, press, press_en, pend_q, pend_clr;
  logic [7:0]      press8;
  logic [7:0]      mem_q [EVQ_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            en_q, drop_q;
  logic            rd_evq, wr_pend, wr_ctrl;
  logic            empty, full, push_req, push, pop, flush, drop_set;

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(EVQ_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign tick = (div_q == DivW'(DEB_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= tick ? '0 : div_q + DivW'(1);
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    xbtn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .btn_raw (btn_raw[i]),
      .stable  (level[i]),
      .press   (press[i])
    );
  end

  assign rd_evq  = bus.sel && !bus.we && (bus.addr == RegEvq);
  assign wr_pend = bus.sel && bus.we && (bus.addr == RegPend);
  assign wr_ctrl = bus.sel && bus.we && (bus.addr == RegCtrl);

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(EVQ_DEPTH));
  assign press_en = en_q ? press : '0;
  assign push_req = |press_en;
  assign pop      = rd_evq && !empty;
  assign flush    = wr_ctrl && bus.data_in[CtrlFlushBit];
  // A pop in the same cycle frees the head slot, so a full queue still accepts the push.
  assign push     = push_req && !flush && (!full || pop);
  assign drop_set = push_req && (multi_hot(press8) || (!flush && full && !pop));
  assign pend_clr = wr_pend ? bus.data_in[NBTN-1:0] : '0;
  assign irq      = en_q && !empty;

  always_comb begin
    press8             = '0;
    press8[NBTN-1:0]   = press_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EVQ_DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      en_q   <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | press_en;
      drop_q <= (drop_q & ~(wr_ctrl && bus.data_in[CtrlDropBit])) | drop_set;
      if (wr_ctrl) en_q <= bus.data_in[CtrlEnBit];
      if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_q] <= lowest_index(press8);
          wr_q        <= ptr_inc(wr_q);
        end
        if (pop) rd_q <= ptr_inc(rd_q);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (reg_addr_e'(bus.addr))
      RegLevel: bus.data_out[NBTN-1:0] = level;
      RegPend:  bus.data_out[NBTN-1:0] = pend_q;
      RegEvq: begin
        if (!empty) begin
          bus.data_out[EvqValidBit] = 1'b1;
          bus.data_out[7:0]         = mem_q[rd_q];
        end
      end
      RegCtrl: begin
        bus.data_out[CtrlEnBit]   = en_q;
        bus.data_out[CtrlDropBit] = drop_q;
      end
      default: bus.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_xbtn_ctrl.sv
// Scoreboarded bench for xbtn_ctrl: directed scenarios plus randomized presses, glitches and bus ops.
module tb_xbtn_ctrl;

  localparam int unsigned NBTN    = 4;
  localparam int unsigned DEB_DIV = 4;
  localparam int unsigned DEB_CNT = 3;
  localparam int unsigned DEPTH   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NBTN-1:0] btn_raw = '0;
  logic            irq;

  xbtn_if bus ();

  xbtn_ctrl #(
    .NBTN      (NBTN),
    .DEB_DIV   (DEB_DIV),
    .DEB_CNT   (DEB_CNT),
    .EVQ_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .btn_raw (btn_raw),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic [3:0] m_level = '0, m_pend = '0, land_val = '0;
  logic       m_en = 1'b0, m_drop = 1'b0;
  int         m_q[$];
  int         cyc = 0;
  int         land_edge = -1;

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[3:0] = m_level;
      2'd1: r[3:0] = m_pend;
      2'd2: if (m_q.size() > 0) begin r[31] = 1'b1; r[7:0] = 8'(m_q[0]); end
      default: begin r[0] = m_en; r[8] = m_drop; end
    endcase
    return r;
  endfunction

  // Edge index at which a level driven just after edge e0 becomes stable.
  function automatic int first_land(input int e0);
    int e;
    e = e0 + 3;
    while ((e % DEB_DIV) != 0) e++;
    return e + DEB_DIV * (DEB_CNT - 1);
  endfunction

  function automatic void apply_edge();
    logic       en_old, flush;
    logic [3:0] pr;
    logic [31:0] d;
    int         idx;
    en_old = m_en;
    flush  = 1'b0;
    d      = bus.data_in;
    if (bus.sel && !bus.we && bus.addr == 2'd2 && m_q.size() > 0) void'(m_q.pop_front());
    if (bus.sel && bus.we && bus.addr == 2'd1) m_pend = m_pend & ~d[3:0];
    if (bus.sel && bus.we && bus.addr == 2'd3) begin
      flush = d[1];
      if (d[8]) m_drop = 1'b0;
      if (flush) m_q.delete();
    end
    if (land_edge == cyc) begin
      pr        = land_val & ~m_level;
      m_level   = land_val;
      land_edge = -1;
      if (en_old && pr != 4'd0) begin
        m_pend = m_pend | pr;
        if ($countones(pr) > 1) m_drop = 1'b1;
        idx = 0;
        for (int i = 3; i >= 0; i--) if (pr[i]) idx = i;
        if (!flush) begin
          if (m_q.size() < DEPTH) m_q.push_back(idx);
          else m_drop = 1'b1;
        end
      end
    end
    if (bus.sel && bus.we && bus.addr == 2'd3) m_en = d[0];
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      cyc++;
      apply_edge();
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_read(input logic [1:0] a);
    exp_q.push_back({a, exp_read(a), (m_en && m_q.size() > 0)});
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    step();
    bus.sel  = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.sel     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    step();
    bus.sel     = 1'b0;
    bus.we      = 1'b0;
  endtask

  task automatic set_raw(input logic [3:0] v, output int land);
    btn_raw   = v;
    land      = first_land(cyc);
    land_edge = land;
    land_val  = v;
  endtask

  task automatic press_release(input logic [3:0] v);
    int l;
    set_raw(v, l);
    idle(16);
    set_raw(4'd0, l);
    idle(16);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b, need %b", name, act, req);
    end
  endtask

  task automatic random_cycle();
    logic [31:0] d;
    case ($urandom_range(0, 7))
      3: bus_read(2'($urandom_range(0, 3)));
      4: bus_write(2'd1, $urandom);
      5: begin
        d    = $urandom;
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 5) == 0);
        bus_write(2'd3, d);
      end
      6, 7: bus_read(2'd2);
      default: step();
    endcase
  endtask

  always @(negedge clk) begin
    if (bus.sel && !bus.we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_read: addr=%0d data=%h with no expectation queued",
                 bus.addr, bus.data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.data_out !== mon_e.data || irq !== mon_e.irq || bus.addr !== mon_e.addr) begin
          n_errors++;
          $display("FAIL read_addr%0d: got data=%h irq=%b, need data=%h irq=%b",
                   mon_e.addr, bus.data_out, irq, mon_e.data, mon_e.irq);
        end
      end
    end
  end

  initial begin
    int          l;
    logic [3:0]  old, g;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) bus_read(2'(a));
    rst = 1'b1;
    cyc = 0;
    for (int a = 0; a < 4; a++) bus_read(2'(a));
    bus_write(2'd3, 32'h1);

    // Clean press of button 0
    set_raw(4'b0001, l);
    idle(16);
    bus_read(2'd0); bus_read(2'd1); bus_read(2'd2); bus_read(2'd2);
    bus_write(2'd1, 32'h1);
    set_raw(4'b0000, l);
    idle(16);

    // Bounce on button 2 never settles
    for (int i = 0; i < 8; i++) begin
      btn_raw[2] = ~btn_raw[2];
      idle(5);
    end
    idle(16);
    bus_read(2'd0); bus_read(2'd1); bus_read(2'd2);

    // Overflow: five presses of button 3
    for (int i = 0; i < 5; i++) press_release(4'b1000);
    bus_read(2'd3); bus_read(2'd1);
    for (int i = 0; i < 5; i++) bus_read(2'd2);
    bus_write(2'd1, 32'hF);
    bus_write(2'd3, 32'h101);

    // Simultaneous presses of buttons 1 and 2
    set_raw(4'b0110, l);
    idle(16);
    bus_read(2'd1); bus_read(2'd2); bus_read(2'd2); bus_read(2'd3);
    set_raw(4'b0000, l);
    idle(16);
    bus_write(2'd1, 32'hF);
    bus_write(2'd3, 32'h101);

    // PEND clear on the same edge the press lands
    set_raw(4'b0001, l);
    while (cyc < l - 1) step();
    bus_write(2'd1, 32'h1);
    bus_read(2'd1);
    set_raw(4'b0000, l);
    idle(16);
    bus_write(2'd1, 32'hF);

    // Full queue: push and pop on the same edge
    for (int i = 0; i < 4; i++) press_release(4'b0001);
    set_raw(4'b0100, l);
    while (cyc < l - 1) step();
    bus_read(2'd2);
    bus_read(2'd3);
    for (int i = 0; i < 5; i++) bus_read(2'd2);
    set_raw(4'b0000, l);
    idle(16);

    // Reset with two entries queued
    press_release(4'b0010);
    press_release(4'b0010);
    bus_read(2'd3);
    rst = 1'b0;
    m_level = '0; m_pend = '0; m_en = 1'b0; m_drop = 1'b0;
    m_q.delete(); land_edge = -1; cyc = 0;
    #1;
    check_bit("irq_on_reset_assert", irq, 1'b0);
    bus_read(2'd2);
    idle(2);
    rst = 1'b1;
    bus_read(2'd2); bus_read(2'd1); bus_read(2'd3); bus_read(2'd0);

    // Randomized phases
    bus_write(2'd3, 32'h1);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          set_raw(4'($urandom), l);
          repeat (16) random_cycle();
        end
        1: begin
          old = btn_raw;
          g   = 4'($urandom_range(1, 15)) ^ old;
          btn_raw = g;
          idle($urandom_range(1, 5));
          btn_raw = old;
          idle(8);
        end
        default: repeat (4) random_cycle();
      endcase
    end

    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
